wb_trace: RTL and testbench

Retire-side trace capture that sits directly downstream of the WB stage of the diad core. Each cycle a retiring instruction is presented, the block stamps it with a free-running cycle tick and pushes pc/instr/result/targets into a circular buffer. The bench or a debug port drains the buffer through a valid/ready handshake. An optional PC-match trigger freezes capture so the history up to a fault can be inspected.

---
 rtl/wb_trace.sv | 157 +++++++++++++++
 tb/tb_wb_trace.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace.sv
// Retire-side trace buffer for the diad core WB stage.
// Circular capture of retiring instructions with PC-match freeze.
module wb_trace #(
   parameter int PC_W    = 48,
   parameter int INSTR_W = 24,
   parameter int DATA_W  = 24,
   parameter int GP_W    = 4,
   parameter int SR_W    = 2,
   parameter int TICK_W  = 16,
   parameter int DEPTH   = 16,
   parameter int DROP_W  = 8
) (
   input  logic                     iw_clk,
   input  logic                     iw_rst,
   input  logic                     iw_wb_valid,
   input  logic [PC_W-1:0]          iw_wb_pc,
   input  logic [INSTR_W-1:0]       iw_wb_instr,
   input  logic [DATA_W-1:0]        iw_wb_result,
   input  logic [GP_W-1:0]          iw_wb_tgt_gp,
   input  logic [SR_W-1:0]          iw_wb_tgt_sr,
   input  logic                     iw_trig_en,
   input  logic [PC_W-1:0]          iw_trig_pc,
   input  logic                     iw_arm,
   input  logic                     iw_clear,
   input  logic                     iw_ready,
   output logic                     ow_valid,
   output logic [TICK_W-1:0]        ow_tick,
   output logic [PC_W-1:0]          ow_pc,
   output logic [INSTR_W-1:0]       ow_instr,
   output logic [DATA_W-1:0]        ow_result,
   output logic [GP_W-1:0]          ow_tgt_gp,
   output logic [SR_W-1:0]          ow_tgt_sr,
   output logic [$clog2(DEPTH):0]   ow_level,
   output logic [DROP_W-1:0]        ow_drop_cnt,
   output logic                     ow_frozen
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [TICK_W-1:0]  tick;
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic [DATA_W-1:0]  result;
      logic [GP_W-1:0]    gp;
      logic [SR_W-1:0]    sr;
   } entry_t;

   typedef enum logic {RUN, FROZEN} state_t;

   entry_t            mem [DEPTH];
   entry_t            head;
   entry_t            wr_entry;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [AW:0]       level;
   logic [TICK_W-1:0] tick;
   logic [DROP_W-1:0] drop_cnt;
   state_t            state;
   logic              frozen_q;

   logic full;
   logic capture;
   logic pop;
   logic push;
   logic drop;
   logic trig_hit;

   always_comb begin
      full     = (level == FULL_LVL);
      capture  = (state == RUN) && iw_wb_valid && !iw_clear;
      pop      = (level != '0) && iw_ready && !iw_clear;
      // a pop on the same edge frees the slot a full-buffer push needs
      push     = capture && (!full || pop);
      drop     = capture && full && !pop;
      trig_hit = capture && iw_trig_en && (iw_wb_pc == iw_trig_pc);
      wr_entry = '{
         tick:   tick,
         pc:     iw_wb_pc,
         instr:  iw_wb_instr,
         result: iw_wb_result,
         gp:     iw_wb_tgt_gp,
         sr:     iw_wb_tgt_sr
      };
   end

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         tick     <= '0;
         drop_cnt <= '0;
         state    <= RUN;
         frozen_q <= 1'b0;
      end else begin
         tick <= tick + TICK_W'(1);
         if (iw_clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
         end else begin
            unique case (state)
               RUN: begin
                  if (trig_hit) begin
                     state    <= FROZEN;
                     frozen_q <= 1'b1;
                  end
               end
               FROZEN: begin
                  if (iw_arm) begin
                     state    <= RUN;
                     frozen_q <= 1'b0;
                  end
               end
               default: begin
                  state    <= RUN;
                  frozen_q <= 1'b0;
               end
            endcase
            if (push) begin
               mem[wr_ptr] <= wr_entry;
               wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
               level <= level + (AW+1)'(1);
            end else if (pop && !push) begin
               level <= level - (AW+1)'(1);
            end
            if (drop && (drop_cnt != '1)) begin
               drop_cnt <= drop_cnt + DROP_W'(1);
            end
         end
      end
   end

   assign head        = mem[rd_ptr];
   assign ow_valid    = (level != '0);
   assign ow_tick     = head.tick;
   assign ow_pc       = head.pc;
   assign ow_instr    = head.instr;
   assign ow_result   = head.result;
   assign ow_tgt_gp   = head.gp;
   assign ow_tgt_sr   = head.sr;
   assign ow_level    = level;
   assign ow_drop_cnt = drop_cnt;
   assign ow_frozen   = frozen_q;

endmodule

// File: tb/tb_wb_trace.sv
// Directed scoreboard bench for wb_trace.
// Expected entries queue on push and are compared on pop.
module tb_wb_trace;

   localparam int PC_W    = 48;
   localparam int INSTR_W = 24;
   localparam int DATA_W  = 24;
   localparam int GP_W    = 4;
   localparam int SR_W    = 2;
   localparam int TICK_W  = 16;
   localparam int DEPTH   = 16;
   localparam int DROP_W  = 8;

   logic               r_clk;
   logic               iw_rst;
   logic               iw_wb_valid;
   logic [PC_W-1:0]    iw_wb_pc;
   logic [INSTR_W-1:0] iw_wb_instr;
   logic [DATA_W-1:0]  iw_wb_result;
   logic [GP_W-1:0]    iw_wb_tgt_gp;
   logic [SR_W-1:0]    iw_wb_tgt_sr;
   logic               iw_trig_en;
   logic [PC_W-1:0]    iw_trig_pc;
   logic               iw_arm;
   logic               iw_clear;
   logic               iw_ready;
   logic               ow_valid;
   logic [TICK_W-1:0]  ow_tick;
   logic [PC_W-1:0]    ow_pc;
   logic [INSTR_W-1:0] ow_instr;
   logic [DATA_W-1:0]  ow_result;
   logic [GP_W-1:0]    ow_tgt_gp;
   logic [SR_W-1:0]    ow_tgt_sr;
   logic [4:0]         ow_level;
   logic [DROP_W-1:0]  ow_drop_cnt;
   logic               ow_frozen;

   wb_trace #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W),
      .GP_W(GP_W), .SR_W(SR_W), .TICK_W(TICK_W),
      .DEPTH(DEPTH), .DROP_W(DROP_W)
   ) dut (
      .iw_clk(r_clk),
      .iw_rst(iw_rst),
      .iw_wb_valid(iw_wb_valid),
      .iw_wb_pc(iw_wb_pc),
      .iw_wb_instr(iw_wb_instr),
      .iw_wb_result(iw_wb_result),
      .iw_wb_tgt_gp(iw_wb_tgt_gp),
      .iw_wb_tgt_sr(iw_wb_tgt_sr),
      .iw_trig_en(iw_trig_en),
      .iw_trig_pc(iw_trig_pc),
      .iw_arm(iw_arm),
      .iw_clear(iw_clear),
      .iw_ready(iw_ready),
      .ow_valid(ow_valid),
      .ow_tick(ow_tick),
      .ow_pc(ow_pc),
      .ow_instr(ow_instr),
      .ow_result(ow_result),
      .ow_tgt_gp(ow_tgt_gp),
      .ow_tgt_sr(ow_tgt_sr),
      .ow_level(ow_level),
      .ow_drop_cnt(ow_drop_cnt),
      .ow_frozen(ow_frozen)
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   typedef struct {
      logic [TICK_W-1:0] tick;
      logic [PC_W-1:0]   pc;
   } ent_t;

   ent_t              sb[$];
   logic [TICK_W-1:0] m_tick;
   int                m_drop;
   bit                m_frozen;
   int                n_chk;
   int                n_fail;

   function automatic logic [INSTR_W-1:0] f_instr(logic [PC_W-1:0] pc);
      return pc[INSTR_W-1:0] ^ 24'h5A5A5A;
   endfunction

   function automatic logic [DATA_W-1:0] f_result(logic [PC_W-1:0] pc);
      return pc[DATA_W-1:0] + 24'h000100;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      check("level", 64'(ow_level), 64'(sb.size()));
      check("drop_cnt", 64'(ow_drop_cnt), 64'(m_drop));
      check("frozen", 64'(ow_frozen), 64'(m_frozen));
      check("valid", 64'(ow_valid), 64'(sb.size() > 0));
   endtask

   task automatic cycle(bit v, logic [PC_W-1:0] pc, bit rdy,
                        bit clr = 1'b0, bit arm = 1'b0);
      bit   full;
      bit   pop;
      bit   cap;
      ent_t e;
      iw_wb_valid  = v;
      iw_wb_pc     = pc;
      iw_wb_instr  = f_instr(pc);
      iw_wb_result = f_result(pc);
      iw_wb_tgt_gp = pc[GP_W-1:0];
      iw_wb_tgt_sr = pc[SR_W-1:0];
      iw_ready     = rdy;
      iw_clear     = clr;
      iw_arm       = arm;
      full = (sb.size() == DEPTH);
      pop  = (sb.size() > 0) && rdy && !clr;
      if (pop) begin
         e = sb.pop_front();
         check("head_valid", 64'(ow_valid), 64'(1));
         check("head_pc", 64'(ow_pc), 64'(e.pc));
         check("head_tick", 64'(ow_tick), 64'(e.tick));
         check("head_instr", 64'(ow_instr), 64'(f_instr(e.pc)));
         check("head_result", 64'(ow_result), 64'(f_result(e.pc)));
         check("head_gp", 64'(ow_tgt_gp), 64'(e.pc[GP_W-1:0]));
         check("head_sr", 64'(ow_tgt_sr), 64'(e.pc[SR_W-1:0]));
      end
      cap = !m_frozen && v && !clr;
      if (cap && (!full || pop)) begin
         sb.push_back('{tick: m_tick, pc: pc});
      end else if (cap) begin
         m_drop = (m_drop == 255) ? 255 : m_drop + 1;
      end
      if (!clr) begin
         if (!m_frozen && v && iw_trig_en && pc == iw_trig_pc) begin
            m_frozen = 1'b1;
         end else if (m_frozen && arm) begin
            m_frozen = 1'b0;
         end
      end
      if (clr) begin
         sb.delete();
         m_drop = 0;
      end
      m_tick = m_tick + 16'd1;
      @(posedge r_clk);
      #1;
      check_state();
   endtask

   task automatic do_reset();
      iw_rst      = 1'b1;
      iw_wb_valid = 1'b0;
      iw_ready    = 1'b1;
      iw_clear    = 1'b0;
      iw_arm      = 1'b0;
      @(posedge r_clk);
      #1;
      iw_rst   = 1'b0;
      sb.delete();
      m_tick   = '0;
      m_drop   = 0;
      m_frozen = 1'b0;
      check_state();
      check("rst_pc", 64'(ow_pc), 64'(0));
      check("rst_tick", 64'(ow_tick), 64'(0));
      check("rst_instr", 64'(ow_instr), 64'(0));
      check("rst_result", 64'(ow_result), 64'(0));
   endtask

   initial begin
      n_chk        = 0;
      n_fail       = 0;
      m_tick       = '0;
      m_drop       = 0;
      m_frozen     = 1'b0;
      iw_rst       = 1'b1;
      iw_wb_valid  = 1'b0;
      iw_wb_pc     = '0;
      iw_wb_instr  = '0;
      iw_wb_result = '0;
      iw_wb_tgt_gp = '0;
      iw_wb_tgt_sr = '0;
      iw_trig_en   = 1'b0;
      iw_trig_pc   = '0;
      iw_arm       = 1'b0;
      iw_clear     = 1'b0;
      iw_ready     = 1'b0;
      @(posedge r_clk);
      #1;
      do_reset();

      // three pushes, then drain in order
      for (int i = 0; i < 3; i++) cycle(1'b1, 48'h10 + 48'(i), 1'b0);
      check("t1_level", 64'(ow_level), 64'(3));
      check("t1_head_pc", 64'(ow_pc), 64'h10);
      check("t1_head_tick", 64'(ow_tick), 64'(0));
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
      check("t1_empty", 64'(ow_valid), 64'(0));

      // overflow counts drops
      for (int i = 0; i < 20; i++) cycle(1'b1, 48'h100 + 48'(i), 1'b0);
      check("t2_level", 64'(ow_level), 64'(16));
      check("t2_drop", 64'(ow_drop_cnt), 64'(4));
      cycle(1'b1, 48'h200, 1'b1);
      check("t2_level_pp", 64'(ow_level), 64'(16));
      check("t2_drop_pp", 64'(ow_drop_cnt), 64'(4));

      // drop counter saturation, then clear
      for (int i = 0; i < 300; i++) cycle(1'b1, 48'h300 + 48'(i), 1'b0);
      check("t3_drop_sat", 64'(ow_drop_cnt), 64'(255));
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("t3_clr_level", 64'(ow_level), 64'(0));
      check("t3_clr_drop", 64'(ow_drop_cnt), 64'(0));

      // PC-match freeze and re-arm
      iw_trig_en = 1'b1;
      iw_trig_pc = 48'h20;
      for (int i = 0; i < 4; i++) cycle(1'b1, 48'h1E + 48'(i), 1'b0);
      check("t4_frozen", 64'(ow_frozen), 64'(1));
      check("t4_level", 64'(ow_level), 64'(3));
      check("t4_drop", 64'(ow_drop_cnt), 64'(0));
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("t4_armed", 64'(ow_frozen), 64'(0));
      iw_trig_en = 1'b0;
      cycle(1'b1, 48'h22, 1'b0);
      check("t4_level_after", 64'(ow_level), 64'(4));
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

      // steady push+pop on a 5-entry buffer, pointers wrap
      for (int i = 0; i < 5; i++) cycle(1'b1, 48'h400 + 48'(i), 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b1, 48'h500 + 48'(i), 1'b1);
      check("t5_level", 64'(ow_level), 64'(5));
      for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

      // reset mid-drain
      for (int i = 0; i < 8; i++) cycle(1'b1, 48'h600 + 48'(i), 1'b0);
      cycle(1'b0, '0, 1'b1);
      check("t6_level_pre", 64'(ow_level), 64'(7));
      do_reset();
      check("t6_valid", 64'(ow_valid), 64'(0));
      cycle(1'b1, 48'h700, 1'b0);
      check("t6_tick0", 64'(ow_tick), 64'(0));
      for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
